// File: rtl/seq_control_pkg.sv
// Shared definitions for the instruction sequence controller: FSM states,
// opcode constants and the execute-phase end step of each opcode.
package seq_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_INDIRECT = 3'd3,
        ST_EXEC     = 3'd4,
        ST_INTR     = 3'd5
    } state_e;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REG_IO = 3'd7;

    // Timing step at which the execute phase of each opcode completes
    function automatic logic [2:0] end_step(input logic [2:0] op);
        logic [2:0] step;
        case (op)
            OP_AND, OP_ADD, OP_LDA: step = 3'd5;
            OP_STA, OP_BUN:         step = 3'd4;
            OP_BSA:                 step = 3'd5;
            OP_ISZ:                 step = 3'd6;
            OP_REG_IO:              step = 3'd3;
            default:                step = 3'd3;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/timing_decoder.sv
// 3-to-8 one-hot decoder with enable; used for both the timing signals and
// the opcode decode.
module timing_decoder (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    // one-hot select, all-zero when disabled
    always_comb begin
        y = 8'h00;
        if (en) begin
            y[sel] = 1'b1;
        end else begin
            y = 8'h00;
        end
    end

endmodule

// File: rtl/seq_control.sv
// Instruction sequence controller: steps fetch/decode/indirect/execute and
// interrupt cycles by commanding an external sequence counter.
module seq_control
    import seq_control_pkg::*;
#(
    parameter int SC_W   = 3,
    parameter int LAST_T = 7
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic [SC_W-1:0] SC_T,
    input  logic [2:0]      IR_OP,
    input  logic            IR_I,
    input  logic            IR_HLT,
    input  logic            START,
    input  logic            IEN,
    input  logic            FGI,
    input  logic            FGO,
    output logic            SC_CLR,
    output logic            SC_INC,
    output logic [7:0]      T,
    output logic [7:0]      D,
    output logic            I_FF,
    output logic            S,
    output logic            R,
    output logic            IEN_CLR,
    output logic            ERR
);

    state_e          state_r, state_nx_s;
    logic            s_r, s_nx_s;
    logic            r_r, r_nx_s;
    logic            i_ff_r, i_ff_nx_s;
    logic            err_r, err_nx_s;
    logic [7:0]      d_r, d_nx_s;
    logic [2:0]      op_r, op_nx_s;
    logic [SC_W-1:0] shadow_r;

    logic            sc_clr_s, sc_inc_s, ien_clr_s;
    logic [31:0]     sc_t_w_s;
    logic [2:0]      t_sel_s;
    logic            t_en_s;
    logic [7:0]      t_dec_s, op_dec_s;
    logic            at_end_s, halt_s, r_set_s, mismatch_s, overrun_s;

    assign sc_t_w_s = 32'(SC_T);
    assign t_sel_s  = sc_t_w_s[2:0];
    assign t_en_s   = s_r && (sc_t_w_s < 32'd8);

    timing_decoder u_t_dec (
        .en  (t_en_s),
        .sel (t_sel_s),
        .y   (t_dec_s)
    );

    timing_decoder u_op_dec (
        .en  (1'b1),
        .sel (IR_OP),
        .y   (op_dec_s)
    );

    assign at_end_s   = (sc_t_w_s == 32'(end_step(op_r)));
    assign halt_s     = (state_r == ST_EXEC) && (op_r == OP_REG_IO) && !i_ff_r
                        && IR_HLT && (sc_t_w_s == 32'd3);
    assign r_set_s    = s_r && (sc_t_w_s >= 32'd3) && IEN && (FGI || FGO);
    assign mismatch_s = s_r && (SC_T != shadow_r);
    // Reaching LAST_T is only legal as the end step of an execute phase
    assign overrun_s  = (sc_t_w_s == 32'(LAST_T)) && !((state_r == ST_EXEC) && at_end_s);

    // next-state, counter commands and register updates
    always_comb begin
        state_nx_s = state_r;
        s_nx_s     = s_r;
        r_nx_s     = r_r;
        i_ff_nx_s  = i_ff_r;
        d_nx_s     = d_r;
        op_nx_s    = op_r;
        err_nx_s   = err_r;
        sc_clr_s   = 1'b0;
        sc_inc_s   = 1'b0;
        ien_clr_s  = 1'b0;

        if (r_set_s) begin
            r_nx_s = 1'b1;
        end else begin
            r_nx_s = r_r;
        end

        case (state_r)
            ST_IDLE: begin
                sc_clr_s = 1'b1;
                if (START) begin
                    s_nx_s     = 1'b1;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                sc_inc_s = 1'b1;
                if (sc_t_w_s >= 32'd1) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                sc_inc_s  = 1'b1;
                d_nx_s    = op_dec_s;
                op_nx_s   = IR_OP;
                i_ff_nx_s = IR_I;
                if (IR_OP == OP_REG_IO) begin
                    state_nx_s = ST_EXEC;
                end else if (IR_I) begin
                    state_nx_s = ST_INDIRECT;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_INDIRECT: begin
                sc_inc_s   = 1'b1;
                state_nx_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt_s) begin
                    sc_clr_s   = 1'b1;
                    s_nx_s     = 1'b0;
                    state_nx_s = ST_IDLE;
                end else if (at_end_s) begin
                    sc_clr_s = 1'b1;
                    if (r_r || r_set_s) begin
                        state_nx_s = ST_INTR;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
                end else begin
                    sc_inc_s   = 1'b1;
                    state_nx_s = ST_EXEC;
                end
            end
            ST_INTR: begin
                if (sc_t_w_s == 32'd2) begin
                    sc_clr_s   = 1'b1;
                    ien_clr_s  = 1'b1;
                    r_nx_s     = 1'b0;
                    state_nx_s = ST_FETCH;
                end else begin
                    sc_inc_s   = 1'b1;
                    state_nx_s = ST_INTR;
                end
            end
            default: begin
                sc_clr_s   = 1'b1;
                s_nx_s     = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase

        // Any count fault stops the machine and parks the counter at zero
        if (mismatch_s || overrun_s) begin
            err_nx_s   = 1'b1;
            s_nx_s     = 1'b0;
            state_nx_s = ST_IDLE;
            sc_clr_s   = 1'b1;
            sc_inc_s   = 1'b0;
            ien_clr_s  = 1'b0;
        end else begin
            err_nx_s = err_r;
        end

        if (CLR) begin
            sc_clr_s  = 1'b1;
            sc_inc_s  = 1'b0;
            ien_clr_s = 1'b0;
        end else begin
            sc_inc_s = sc_inc_s;
        end
    end

    // state, flags and shadow count
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r  <= ST_IDLE;
            s_r      <= 1'b0;
            r_r      <= 1'b0;
            i_ff_r   <= 1'b0;
            err_r    <= 1'b0;
            d_r      <= 8'h00;
            op_r     <= 3'd0;
            shadow_r <= {SC_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            s_r     <= s_nx_s;
            r_r     <= r_nx_s;
            i_ff_r  <= i_ff_nx_s;
            err_r   <= err_nx_s;
            d_r     <= d_nx_s;
            op_r    <= op_nx_s;
            if (sc_clr_s) begin
                shadow_r <= {SC_W{1'b0}};
            end else if (sc_inc_s) begin
                shadow_r <= shadow_r + SC_W'(1);
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    assign SC_CLR  = sc_clr_s;
    assign SC_INC  = sc_inc_s;
    assign IEN_CLR = ien_clr_s;
    assign T       = t_dec_s;
    assign D       = d_r;
    assign I_FF    = i_ff_r;
    assign S       = s_r;
    assign R       = r_r;
    assign ERR     = err_r;

endmodule

// File: tb/tb_seq_control.sv
// Bench for seq_control driving a simple sequence counter; expected traces
// come from the opcode end-step rules, not from the controller's FSM.
module tb_seq_control;

    logic       CLK = 1'b0;
    logic       CLR, START, IR_I, IR_HLT, IEN, FGI, FGO;
    logic [2:0] IR_OP, SC_T;
    logic       SC_CLR, SC_INC, I_FF, S, R, IEN_CLR, ERR;
    logic [7:0] T, D;

    logic [2:0] sc_cnt;
    logic       force_en;
    logic [2:0] force_val;

    int n_vec  = 0;
    int n_miss = 0;
    bit m_s, m_r, m_err;

    typedef struct {
        logic [2:0] op;
        bit         ind;
        bit         hlt;
        int         irq_k;
        int         exp_end;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl[10];
    int   ref_end[8] = '{5, 5, 5, 4, 4, 5, 6, 3};

    always #5 CLK = ~CLK;

    // sequence counter under the controller's command, with a test override
    always @(posedge CLK) begin
        if (SC_CLR)      sc_cnt <= 3'd0;
        else if (SC_INC) sc_cnt <= sc_cnt + 3'd1;
    end
    assign SC_T = force_en ? force_val : sc_cnt;

    seq_control #(.SC_W(3), .LAST_T(7)) dut (
        .CLK(CLK), .CLR(CLR), .SC_T(SC_T), .IR_OP(IR_OP), .IR_I(IR_I),
        .IR_HLT(IR_HLT), .START(START), .IEN(IEN), .FGI(FGI), .FGO(FGO),
        .SC_CLR(SC_CLR), .SC_INC(SC_INC), .T(T), .D(D), .I_FF(I_FF),
        .S(S), .R(R), .IEN_CLR(IEN_CLR), .ERR(ERR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // {SC_T, SC_CLR, SC_INC, T, S, R, IEN_CLR, ERR} against the model
    task automatic expect_cyc(input string tag, input int sct, input bit clr, input bit inc, input bit ienclr);
        logic [7:0] t_exp;
        t_exp = m_s ? (8'h01 << sct) : 8'h00;
        chk(tag, 32'({SC_T, SC_CLR, SC_INC, T, S, R, IEN_CLR, ERR}),
                 32'({3'(sct), clr, inc, t_exp, m_s, m_r, ienclr, m_err}));
    endtask

    task automatic start_seq(input string tag);
        START = 1'b1;
        @(negedge CLK);
        expect_cyc(tag, 0, 1'b1, 1'b0, 1'b0);
        tick();
        START = 1'b0;
        m_s   = 1'b1;
    endtask

    // One instruction from FETCH T0: steps T0..end, then halt or interrupt cycle
    task automatic run_instr(input logic [2:0] op, input bit ind, input bit hlt, input int irq_k,
                             input int e, input logic [7:0] d_exp, input string tag);
        IR_OP  = op;
        IR_I   = ind;
        IR_HLT = hlt;
        for (int k = 0; k <= e; k++) begin
            IEN   = (k == irq_k);
            FGI   = (k == irq_k) && 1'($urandom_range(0, 1));
            FGO   = (k == irq_k) && !FGI;
            START = 1'($urandom_range(0, 1));
            @(negedge CLK);
            expect_cyc(tag, k, k == e, k < e, 1'b0);
            if (k == 3) begin
                chk({tag, "_d"}, 32'(D), 32'(d_exp));
                chk({tag, "_iff"}, 32'(I_FF), 32'(ind));
            end
            if (k >= 3 && k == irq_k) m_r = 1'b1;
            tick();
        end
        IEN = 1'b0; FGI = 1'b0; FGO = 1'b0; START = 1'b0;
        if (op == 3'd7 && !ind && hlt) begin
            m_s = 1'b0;
            @(negedge CLK);
            expect_cyc({tag, "_halted"}, 0, 1'b1, 1'b0, 1'b0);
            tick();
            start_seq({tag, "_restart"});
        end else if (m_r) begin
            for (int k = 0; k <= 2; k++) begin
                @(negedge CLK);
                expect_cyc({tag, "_intr"}, k, k == 2, k < 2, k == 2);
                tick();
            end
            m_r = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'd1, 1'b0, 1'b0, -1, 5, 8'h02};   // ADD direct
        tbl[1] = '{3'd6, 1'b1, 1'b0, -1, 6, 8'h40};   // ISZ indirect
        tbl[2] = '{3'd2, 1'b0, 1'b0,  4, 5, 8'h04};   // LDA, interrupt at T4
        tbl[3] = '{3'd3, 1'b1, 1'b0,  2, 4, 8'h08};   // STA, flag at T2 is too early
        tbl[4] = '{3'd4, 1'b0, 1'b0,  4, 4, 8'h10};   // BUN, flag on the end step
        tbl[5] = '{3'd0, 1'b1, 1'b0, -1, 5, 8'h01};   // AND indirect
        tbl[6] = '{3'd7, 1'b0, 1'b1, -1, 3, 8'h80};   // HLT
        tbl[7] = '{3'd7, 1'b1, 1'b1,  3, 3, 8'h80};   // I/O, not a halt
        tbl[8] = '{3'd5, 1'b0, 1'b0, -1, 5, 8'h20};   // BSA direct
        tbl[9] = '{3'd7, 1'b0, 1'b0, -1, 3, 8'h80};   // register ref, no halt

        CLR = 1'b1; START = 1'b1; IR_OP = 3'd0; IR_I = 1'b0; IR_HLT = 1'b0;
        IEN = 1'b0; FGI = 1'b0; FGO = 1'b0; force_en = 1'b0; force_val = 3'd0;
        m_s = 1'b0; m_r = 1'b0; m_err = 1'b0;

        @(negedge CLK);
        chk("rst_cmd", 32'({SC_CLR, SC_INC, IEN_CLR}), 32'(3'b100));
        chk("rst_regs", 32'({S, R, I_FF, ERR, D}), 32'd0);
        tick();
        CLR = 1'b0; START = 1'b0;
        @(negedge CLK);
        expect_cyc("idle", 0, 1'b1, 1'b0, 1'b0);
        tick();
        start_seq("start");

        for (int i = 0; i < 10; i++)
            run_instr(tbl[i].op, tbl[i].ind, tbl[i].hlt, tbl[i].irq_k,
                      tbl[i].exp_end, tbl[i].exp_d, $sformatf("tbl%0d", i));

        // CLR in the middle of BSA
        IR_OP = 3'd5; IR_I = 1'b0; IR_HLT = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            expect_cyc("bsa_pre", k, 1'b0, 1'b1, 1'b0);
            tick();
        end
        CLR = 1'b1;
        @(negedge CLK);
        chk("bsa_clr_cmd", 32'({SC_CLR, SC_INC}), 32'(2'b10));
        tick();
        CLR = 1'b0;
        m_s = 1'b0; m_r = 1'b0;
        @(negedge CLK);
        chk("bsa_post", 32'({SC_T, SC_CLR, S, D, ERR}), 32'({3'd0, 1'b1, 1'b0, 8'h00, 1'b0}));
        tick();
        start_seq("bsa_restart");

        // count mismatch at FETCH T1
        IR_OP = 3'd1;
        @(negedge CLK);
        expect_cyc("err_t0", 0, 1'b0, 1'b1, 1'b0);
        tick();
        force_val = 3'd3; force_en = 1'b1;
        @(negedge CLK);
        chk("err_force_cmd", 32'({SC_CLR, SC_INC}), 32'(2'b10));
        tick();
        force_en = 1'b0;
        m_s = 1'b0; m_err = 1'b1;
        @(negedge CLK);
        expect_cyc("err_after", 0, 1'b1, 1'b0, 1'b0);
        tick();
        start_seq("err_restart");
        run_instr(3'd1, 1'b0, 1'b0, -1, 5, 8'h02, "err_sticky");
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        m_s = 1'b0; m_r = 1'b0; m_err = 1'b0;
        @(negedge CLK);
        expect_cyc("err_cleared", 0, 1'b1, 1'b0, 1'b0);
        tick();

        // count reaching LAST_T while idle
        force_val = 3'd7; force_en = 1'b1;
        @(negedge CLK);
        chk("ovr_cmd", 32'({SC_CLR, SC_INC}), 32'(2'b10));
        tick();
        force_en = 1'b0;
        m_err = 1'b1;
        @(negedge CLK);
        expect_cyc("ovr_after", 0, 1'b1, 1'b0, 1'b0);
        tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        m_err = 1'b0;
        start_seq("rand_start");

        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            bit         ind, hlt;
            int         irq;
            op  = 3'($urandom_range(0, 7));
            ind = 1'($urandom_range(0, 1));
            hlt = 1'($urandom_range(0, 1));
            irq = (op == 3'd7 && !ind && hlt) ? -1 : int'($urandom_range(0, 7));
            run_instr(op, ind, hlt, irq, ref_end[op], 8'h01 << op, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
